io_slot_bus: RTL and testbench

Parametrised IO-space controller between the core's IO port and up to NSLOT peripheral slots. It replaces the fixed, single-cycle LEDS-style decode with:
- a one-hot slot select per access;
- a per-slot ready handshake, so slow peripherals can insert wait states;
- a busy indication back to the core;
- bus-error responses for unmapped addresses and for slots that never answer.

---
 rtl/io_slot_bus_if.sv | 40 ++++
 rtl/io_slot_bus.sv | 150 +++++++++++++++
 tb/tb_io_slot_bus.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/io_slot_bus_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_slot_bus_if : core IO port + peripheral slot bundle for io_slot_bus
// Revision: 1.0
// ----------------------------------------------------------------------------
interface io_slot_bus_if #(
  parameter int ADDR_W     = 14,
  parameter int NSLOT      = 8,
  parameter int SLOT_SHIFT = 4
);
  logic                  DBE;
  logic                  IO_REQ;
  logic                  IO_WE;
  logic                  IO_RE;
  logic [ADDR_W-1:0]     IO_ADDR;
  logic [31:0]           IO_WD;
  logic [31:0]           IO_RD;
  logic                  IO_BUSY;
  logic                  IO_ACK;
  logic                  IO_ERR;
  logic [NSLOT-1:0]      SL_SEL;
  logic                  SL_WE;
  logic                  SL_RE;
  logic [SLOT_SHIFT-1:0] SL_A;
  logic [31:0]           SL_WD;
  logic [NSLOT*32-1:0]   SL_RD;
  logic [NSLOT-1:0]      SL_RDY;

  // master is the environment (core and peripheral slots); slave is the controller
  modport master (
    output DBE, IO_REQ, IO_WE, IO_RE, IO_ADDR, IO_WD, SL_RD, SL_RDY,
    input  IO_RD, IO_BUSY, IO_ACK, IO_ERR, SL_SEL, SL_WE, SL_RE, SL_A, SL_WD
  );

  modport slave (
    input  DBE, IO_REQ, IO_WE, IO_RE, IO_ADDR, IO_WD, SL_RD, SL_RDY,
    output IO_RD, IO_BUSY, IO_ACK, IO_ERR, SL_SEL, SL_WE, SL_RE, SL_A, SL_WD
  );
endinterface
`default_nettype wire

// File: rtl/io_slot_bus.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_slot_bus : IO-space decoder with one-hot slot select, ready wait states
//               and bus-error responses for unmapped or silent slots
// Revision: 1.0
// ----------------------------------------------------------------------------
module io_slot_bus #(
  parameter int ADDR_W     = 14,
  parameter int NSLOT      = 8,
  parameter int SLOT_SHIFT = 4,
  parameter int TIMEOUT    = 15
) (
  input  wire logic     CLK,
  input  wire logic     RESET_N,
  io_slot_bus_if.slave  bus
);

  localparam int         SEL_W   = $clog2(NSLOT);
  localparam int         HI_LSB  = SLOT_SHIFT + SEL_W;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SEL_W-1:0]      r_idx;
  logic [SLOT_SHIFT-1:0] r_off;
  logic [31:0]           r_wd;
  logic [31:0]           r_rd;
  logic                  r_we;
  logic                  r_re;
  logic                  r_err;
  logic [7:0]            r_cnt;

  logic                  w_mapped;
  logic                  w_accept;
  logic                  w_rdy;
  logic                  w_last;
  logic                  w_busy;
  logic                  w_ack;
  logic [31:0]           w_rd_slot [NSLOT];
  logic [31:0]           w_rd_sel;

  // Mapped means every address bit above the slot-index field is zero
  generate
    if (HI_LSB < ADDR_W) begin : g_hi_bits
      assign w_mapped = (bus.IO_ADDR[ADDR_W-1:HI_LSB] == '0);
    end else begin : g_no_hi_bits
      assign w_mapped = 1'b1;
    end
  endgenerate

  generate
    for (genvar k = 0; k < NSLOT; k++) begin : g_rd_slot
      assign w_rd_slot[k] = bus.SL_RD[32*k +: 32];
    end
  endgenerate

  assign w_accept = (r_state != S_ACCESS) & bus.IO_REQ & ~bus.DBE & (bus.IO_WE | bus.IO_RE);
  assign w_rdy    = bus.SL_RDY[r_idx];
  assign w_rd_sel = w_rd_slot[r_idx];
  assign w_last   = (r_cnt == TO_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        w_ack = (r_state == S_RESP);
        if (w_accept) begin
          w_state_nxt = w_mapped ? S_ACCESS : S_RESP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        w_busy = 1'b1;
        if (w_rdy || w_last) begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ready is checked before the timeout, so ready in the last allowed cycle wins
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_idx <= '0;
      r_off <= '0;
      r_wd  <= '0;
      r_rd  <= '0;
      r_we  <= 1'b0;
      r_re  <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_idx <= bus.IO_ADDR[SLOT_SHIFT +: SEL_W];
      r_off <= bus.IO_ADDR[SLOT_SHIFT-1:0];
      r_wd  <= bus.IO_WD;
      r_we  <= bus.IO_WE;
      r_re  <= bus.IO_RE & ~bus.IO_WE;
      r_err <= ~w_mapped;
      r_cnt <= '0;
      if (!w_mapped && bus.IO_RE && !bus.IO_WE) begin
        r_rd <= '0;
      end
    end else if (r_state == S_ACCESS) begin
      if (w_rdy) begin
        r_err <= 1'b0;
        if (r_re) begin
          r_rd <= w_rd_sel;
        end
      end else if (w_last) begin
        r_err <= 1'b1;
        if (r_re) begin
          r_rd <= '0;
        end
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign bus.IO_RD   = r_rd;
  assign bus.IO_BUSY = w_busy;
  assign bus.IO_ACK  = w_ack;
  assign bus.IO_ERR  = w_ack & r_err;

  assign bus.SL_SEL  = w_busy ? ({{(NSLOT-1){1'b0}}, 1'b1} << r_idx) : '0;
  assign bus.SL_WE   = w_busy & r_we;
  assign bus.SL_RE   = w_busy & r_re;
  assign bus.SL_A    = w_busy ? r_off : '0;
  assign bus.SL_WD   = w_busy ? r_wd : '0;

endmodule
`default_nettype wire

// File: tb/tb_io_slot_bus.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_io_slot_bus : directed, scoreboard-checked bench for io_slot_bus
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_io_slot_bus;

  localparam int ADDR_W     = 14;
  localparam int NSLOT      = 8;
  localparam int SLOT_SHIFT = 4;
  localparam int TIMEOUT    = 15;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;

  always #5 CLK = ~CLK;

  io_slot_bus_if #(.ADDR_W(ADDR_W), .NSLOT(NSLOT), .SLOT_SHIFT(SLOT_SHIFT)) bus ();

  io_slot_bus #(
    .ADDR_W(ADDR_W), .NSLOT(NSLOT), .SLOT_SHIFT(SLOT_SHIFT), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] slot_data [NSLOT];

  logic [NSLOT-1:0]      exp_sel;
  logic                  exp_we;
  logic                  exp_re;
  logic [SLOT_SHIFT-1:0] exp_a;
  logic [31:0]           exp_wd;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic re, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wd, input logic push,
                       input logic e_err, input logic [31:0] e_rd);
    logic mapped;
    bus.IO_REQ  = 1'b1;
    bus.IO_WE   = we;
    bus.IO_RE   = re;
    bus.IO_ADDR = addr;
    bus.IO_WD   = wd;
    mapped  = (addr[ADDR_W-1:7] == '0);
    exp_sel = mapped ? (8'h01 << addr[6:4]) : 8'h00;
    exp_we  = we;
    exp_re  = re & ~we;
    exp_a   = addr[3:0];
    exp_wd  = wd;
    if (push) sb_q.push_back('{err: e_err, rd: e_rd});
  endtask

  task automatic sb_pop_check(input string tag);
    exp_t e;
    chk({tag, "_sbq"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_ack"}, 32'(bus.IO_ACK), 32'd1);
      chk({tag, "_err"}, 32'(bus.IO_ERR), 32'(e.err));
      chk({tag, "_rd"},  bus.IO_RD, e.rd);
    end
  endtask

  // Counts ACCESS cycles until ACK, checking held strobes; can raise ready mid-access
  task automatic run_to_ack(input string tag, input int rdy_at,
                            input logic [NSLOT-1:0] rdy_bits, input int exp_cycles);
    int   n   = 0;
    logic got = 1'b0;
    for (int t = 0; t < 64; t++) begin
      tick();
      if (t == 0) bus.IO_REQ = 1'b0;
      if (bus.IO_ACK) begin
        got = 1'b1;
        break;
      end
      n++;
      chk({tag, "_sel"},  32'(bus.SL_SEL),  32'(exp_sel));
      chk({tag, "_we"},   32'(bus.SL_WE),   32'(exp_we));
      chk({tag, "_re"},   32'(bus.SL_RE),   32'(exp_re));
      chk({tag, "_a"},    32'(bus.SL_A),    32'(exp_a));
      chk({tag, "_wd"},   bus.SL_WD,        exp_wd);
      chk({tag, "_busy"}, 32'(bus.IO_BUSY), 32'd1);
      if (n == rdy_at) bus.SL_RDY = rdy_bits;
    end
    chk({tag, "_gotack"}, 32'(got), 32'd1);
    if (got) begin
      sb_pop_check(tag);
      chk({tag, "_cycles"},  32'(n),            32'(exp_cycles));
      chk({tag, "_selidle"}, 32'(bus.SL_SEL),   32'd0);
      chk({tag, "_busyoff"}, 32'(bus.IO_BUSY),  32'd0);
    end
  endtask

  initial begin
    bus.DBE     = 1'b0;
    bus.IO_REQ  = 1'b0;
    bus.IO_WE   = 1'b0;
    bus.IO_RE   = 1'b0;
    bus.IO_ADDR = '0;
    bus.IO_WD   = '0;
    bus.SL_RDY  = '0;
    for (int k = 0; k < NSLOT; k++) begin
      slot_data[k] = (k == 0) ? 32'h1234_5678 : (32'hA000_0000 | (32'h0101_0101 * k));
      bus.SL_RD[32*k +: 32] = slot_data[k];
    end

    // Reset state
    tick();
    tick();
    chk("rst_rd",   bus.IO_RD,             32'd0);
    chk("rst_busy", 32'(bus.IO_BUSY),      32'd0);
    chk("rst_ack",  32'(bus.IO_ACK),       32'd0);
    chk("rst_err",  32'(bus.IO_ERR),       32'd0);
    chk("rst_sel",  32'(bus.SL_SEL),       32'd0);
    chk("rst_we",   32'(bus.SL_WE),        32'd0);
    chk("rst_re",   32'(bus.SL_RE),        32'd0);
    chk("rst_a",    32'(bus.SL_A),         32'd0);
    chk("rst_wd",   bus.SL_WD,             32'd0);
    RESET_N = 1'b1;
    tick();

    // Zero-wait read of slot 0
    bus.SL_RDY = 8'h01;
    issue(1'b0, 1'b1, 14'h003, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
    run_to_ack("rd0", 0, 8'h00, 1);
    tick();
    chk("rd0_single", 32'(bus.IO_ACK), 32'd0);

    // Write to slot 3 with three wait states; other slots' ready must be ignored
    bus.SL_RDY = 8'hF7;
    issue(1'b1, 1'b0, 14'h035, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h1234_5678);
    run_to_ack("wr3", 4, 8'hFF, 4);
    bus.SL_RDY = 8'h00;
    tick();
    chk("wr3_single", 32'(bus.IO_ACK), 32'd0);

    // Timeout on slot 5
    issue(1'b0, 1'b1, 14'h050, 32'h0, 1'b1, 1'b1, 32'h0);
    run_to_ack("to5", 0, 8'h00, TIMEOUT);
    tick();

    // Ready in the final allowed cycle succeeds
    bus.SL_RDY = 8'h00;
    issue(1'b0, 1'b1, 14'h052, 32'h0, 1'b1, 1'b0, slot_data[5]);
    run_to_ack("to5_last", TIMEOUT, 8'h20, TIMEOUT);
    tick();

    // Unmapped read, then back-to-back accesses issued in each RESP cycle
    bus.SL_RDY = 8'hFF;
    issue(1'b0, 1'b1, 14'h100, 32'h0, 1'b1, 1'b1, 32'h0);
    run_to_ack("unm", 0, 8'h00, 0);
    issue(1'b0, 1'b1, 14'h010, 32'h0, 1'b1, 1'b0, slot_data[1]);
    run_to_ack("b2b_rd", 0, 8'h00, 1);
    issue(1'b1, 1'b0, 14'h02A, 32'h5A5A_0001, 1'b1, 1'b0, slot_data[1]);
    run_to_ack("b2b_wr", 0, 8'h00, 1);
    tick();

    // DBE discards the request
    bus.DBE     = 1'b1;
    bus.IO_REQ  = 1'b1;
    bus.IO_RE   = 1'b1;
    bus.IO_WE   = 1'b0;
    bus.IO_ADDR = 14'h010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dbe_sel", 32'(bus.SL_SEL), 32'd0);
      chk("dbe_ack", 32'(bus.IO_ACK), 32'd0);
    end
    bus.DBE    = 1'b0;
    bus.IO_REQ = 1'b0;
    tick();

    // Request while busy is ignored
    bus.SL_RDY = 8'h00;
    issue(1'b0, 1'b1, 14'h060, 32'h0, 1'b1, 1'b0, slot_data[6]);
    tick();
    chk("busy_sel0", 32'(bus.SL_SEL), 32'h40);
    bus.IO_ADDR = 14'h070;
    bus.IO_WE   = 1'b1;
    tick();
    chk("busy_sel1", 32'(bus.SL_SEL), 32'h40);
    chk("busy_we",   32'(bus.SL_WE),  32'd0);
    bus.SL_RDY = 8'h40;
    bus.IO_REQ = 1'b0;
    bus.IO_WE  = 1'b0;
    tick();
    sb_pop_check("busy");
    tick();
    chk("busy_single", 32'(bus.IO_ACK), 32'd0);

    // Write and read both set: write wins, read data unchanged
    bus.SL_RDY = 8'hFF;
    issue(1'b1, 1'b1, 14'h022, 32'h0BAD_BEEF, 1'b1, 1'b0, slot_data[6]);
    run_to_ack("werw", 0, 8'h00, 1);
    tick();

    // Asynchronous reset during an access with ready pending
    bus.SL_RDY = 8'h00;
    issue(1'b0, 1'b1, 14'h070, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mid_sel", 32'(bus.SL_SEL), 32'h80);
    bus.IO_REQ = 1'b0;
    bus.SL_RDY = 8'h80;
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_sel",  32'(bus.SL_SEL),  32'd0);
    chk("arst_re",   32'(bus.SL_RE),   32'd0);
    chk("arst_busy", 32'(bus.IO_BUSY), 32'd0);
    chk("arst_ack",  32'(bus.IO_ACK),  32'd0);
    chk("arst_rd",   bus.IO_RD,        32'd0);
    tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_noack", 32'(bus.IO_ACK), 32'd0);
    end
    issue(1'b0, 1'b1, 14'h070, 32'h0, 1'b1, 1'b0, slot_data[7]);
    run_to_ack("post_rst", 0, 8'h00, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
